mouse_tx_arbiter: RTL and testbench
===================================

Name: mouse_tx_arbiter

Overview:
- Shares the single PS/2 transmitter, and the acknowledge path of the receiver, between several host-command requesters.
- Typical requesters: the mouse init/stream master, a sample-rate/resolution configurator, a debug command injector.
- Grants one requester at a time (round-robin), sends its byte, waits for the mouse acknowledge (FA), retries on resend (FE), and returns a per-requester pass/fail result.
- Sits between the requesters and the transmitter/receiver pair.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- TIMEOUT_CYCLES, 2000000, cycles allowed from BYTE_SENT to acknowledge (20 ms at 100 MHz).
- MAX_RETRY, 2, resends allowed after an FE response before reporting failure.

Ports:
- CLK  in  1  system clock, 100 MHz.
- RESET  in  1  asynchronous, active-low reset.
- REQ  in  NUM_REQ  per-requester request level; held until DONE.
- REQ_BYTE  in  8*NUM_REQ  command byte of requester i at bits [8i+7:8i]; stable while REQ[i] is high.
- GRANT  out  NUM_REQ  one-hot; current owner.
- DONE  out  NUM_REQ  one-cycle pulse to the owner at end of transaction.
- ACK_OK  out  1  valid with DONE: 1 = FA received, 0 = failure.
- SEND_BYTE  out  1  one-cycle pulse to the transmitter.
- BYTE_TO_SEND  out  8  byte presented to the transmitter.
- BYTE_SENT  in  1  transmitter completion pulse.
- READ_ENABLE  out  1  receiver enable; high in WAIT_ACK.
- BYTE_READ  in  8  received byte.
- BYTE_ERROR_CODE  in  2  receiver error; 00 = good.
- BYTE_READY  in  1  receiver byte-valid pulse.
- BUSY  out  1  high in any state other than IDLE.

Behaviour:
- Reset (RESET = 0, asynchronous): state IDLE; GRANT, DONE, ACK_OK, SEND_BYTE, READ_ENABLE and BUSY all 0; BYTE_TO_SEND = 8'hFF; round-robin pointer = 0; retry and timeout counters = 0.
- All outputs are registered.
- IDLE:
  - Scan REQ starting at the pointer.
  - On the first set bit k: GRANT = onehot(k), latch REQ_BYTE[k] into BYTE_TO_SEND, go to SEND.
  - Grant appears one cycle after REQ rises.
- SEND: SEND_BYTE = 1 for exactly one cycle; go to WAIT_SENT.
- WAIT_SENT: wait for BYTE_SENT, then clear the timeout counter and go to WAIT_ACK. No timeout in this state; the transmitter owns its own timing.
- WAIT_ACK: READ_ENABLE = 1; the timeout counter increments every cycle. On BYTE_READY:
  - BYTE_READ = FA and BYTE_ERROR_CODE = 00: ACK_OK = 1, go to FINISH.
  - BYTE_READ = FE, error 00, retry count < MAX_RETRY: increment retry count, go to SEND (same byte).
  - Any other byte, a nonzero error code, or FE with retries exhausted: ACK_OK = 0, go to FINISH.
  - Counter reaches TIMEOUT_CYCLES-1 with no BYTE_READY: ACK_OK = 0, go to FINISH.
  - BYTE_READY in the same cycle as the timeout: the byte wins.
- FINISH:
  - DONE[k] = 1 for one cycle, with ACK_OK valid in the same cycle.
  - Then GRANT = 0, pointer = (k+1) mod NUM_REQ, retry count = 0, go to IDLE.
  - A requester still holding REQ after DONE is treated as a new request; it waits its round-robin turn.
- Request withdrawn mid-transaction (REQ[k] drops after grant): the transaction runs to completion; DONE is still pulsed.
- Unused/illegal state encodings: go to IDLE with reset values.
- BYTE_READY outside WAIT_ACK is ignored.
- Stream-mode data bytes are never consumed here; the stream master owns the receiver outside transactions.
- Timeout counter width: clog2(TIMEOUT_CYCLES).

Optional Feature:
- Macro: MOUSE_ARB_LOCK_EN.
- Defined: adds input LOCK [NUM_REQ].
  - At FINISH, if LOCK[k] = 1 and REQ[k] = 1, the grant is kept and the state goes straight to SEND with the new REQ_BYTE[k], one idle cycle after DONE.
  - The pointer is not advanced.
  - Use: atomic multi-byte commands such as F3 followed by the rate byte.
  - LOCK is ignored for non-owners.
- Undefined: no LOCK port; every transaction re-arbitrates.

Decomposition:
- Package mouse_pkg holds:
  - byte constants PS2_ACK = 8'hFA, PS2_RESEND = 8'hFE, PS2_RESET = 8'hFF, PS2_STREAM_ON = 8'hF4;
  - the arbiter state enum (IDLE, SEND, WAIT_SENT, WAIT_ACK, FINISH);
  - the receiver error-code constants.
- Sub-module rr_pick: combinational round-robin selector. Inputs: request vector and pointer. Outputs: one-hot grant and a valid flag.

Test Plan:
- Single request: REQ = 01, REQ_BYTE[0] = F4, BYTE_SENT after 50 cycles, then FA with error 00 → one SEND_BYTE pulse with BYTE_TO_SEND = F4; DONE = 01 with ACK_OK = 1; BUSY low afterwards.
- Contention: REQ = 11 from reset → requester 0 served first, then requester 1; next simultaneous REQ = 11 serves requester 1 first.
- Resend: response FE, FE, FA → three SEND_BYTE pulses, then ACK_OK = 1. With FE ×3 and MAX_RETRY = 2 → three sends, then ACK_OK = 0.
- Timeout: TIMEOUT_CYCLES = 100, no BYTE_READY after BYTE_SENT → DONE exactly 100 cycles after WAIT_ACK entry, ACK_OK = 0. Same test with BYTE_READY = FA on the final cycle → ACK_OK = 1.
- Errors: FA with BYTE_ERROR_CODE = 01 → ACK_OK = 0, no retry. RESET asserted during WAIT_ACK → all outputs return to reset values immediately, without waiting for a clock edge.
- Lock (MOUSE_ARB_LOCK_EN defined): requester 1 holds LOCK and sends F3 then 28 while requester 0 is requesting → both bytes sent back-to-back before requester 0 is granted.

Source files
------------

// File: rtl/mouse_pkg.sv
// Shared PS/2 host-command constants and arbiter state encoding.
// Used by mouse_tx_arbiter and its round-robin selector.
package mouse_pkg;

    localparam logic [7:0] PS2_ACK       = 8'hFA;
    localparam logic [7:0] PS2_RESEND    = 8'hFE;
    localparam logic [7:0] PS2_RESET     = 8'hFF;
    localparam logic [7:0] PS2_STREAM_ON = 8'hF4;

    localparam logic [1:0] RX_OK      = 2'b00;
    localparam logic [1:0] RX_PARITY  = 2'b01;
    localparam logic [1:0] RX_FRAME   = 2'b10;
    localparam logic [1:0] RX_TIMEOUT = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_SENT,
        WAIT_ACK,
        FINISH
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr.
// Produces a one-hot grant plus a valid flag.
module rr_pick #(
    parameter int N  = 2,
    parameter int PW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic          valid
);

    always_comb begin
        grant = '0;
        valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < N; k++) begin
                if (!valid && req[k] && k == (int'(ptr) + i) % N) begin
                    grant[k] = 1'b1;
                    valid    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mouse_tx_arbiter.sv
// Round-robin owner of the PS/2 transmitter and acknowledge path.
// Optional MOUSE_ARB_LOCK_EN adds LOCK for back-to-back multi-byte commands.
module mouse_tx_arbiter
    import mouse_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int MAX_RETRY      = 2
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [NUM_REQ-1:0]   REQ,
    input  logic [8*NUM_REQ-1:0] REQ_BYTE,
`ifdef MOUSE_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]   LOCK,
`endif
    output logic [NUM_REQ-1:0]   GRANT,
    output logic [NUM_REQ-1:0]   DONE,
    output logic                 ACK_OK,
    output logic                 SEND_BYTE,
    output logic [7:0]           BYTE_TO_SEND,
    input  logic                 BYTE_SENT,
    output logic                 READ_ENABLE,
    input  logic [7:0]           BYTE_READ,
    input  logic [1:0]           BYTE_ERROR_CODE,
    input  logic                 BYTE_READY,
    output logic                 BUSY
);

    localparam int PW = $clog2(NUM_REQ);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam int RW = $clog2(MAX_RETRY + 2);

    arb_state_t         state;
    logic [PW-1:0]      ptr;
    logic [PW-1:0]      own;
    logic [PW-1:0]      nxt_ptr;
    logic [RW-1:0]      retry;
    logic [TW-1:0]      tcnt;
    logic [NUM_REQ-1:0] pick;
    logic               pick_valid;
    logic [PW-1:0]      pick_idx;
    logic [7:0]         pick_byte;
    logic               rx_ack;
    logic               rx_resend;
`ifdef MOUSE_ARB_LOCK_EN
    logic               locked;
    logic [7:0]         own_byte;
`endif

    rr_pick #(
        .N  (NUM_REQ),
        .PW (PW)
    ) u_pick (
        .req   (REQ),
        .ptr   (ptr),
        .grant (pick),
        .valid (pick_valid)
    );

    always_comb begin
        pick_idx  = '0;
        pick_byte = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick[i]) begin
                pick_idx  = PW'(i);
                pick_byte = REQ_BYTE[i*8 +: 8];
            end
        end
    end

`ifdef MOUSE_ARB_LOCK_EN
    always_comb begin
        own_byte = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (own == PW'(i)) own_byte = REQ_BYTE[i*8 +: 8];
        end
    end
`endif

    assign nxt_ptr   = (own == PW'(NUM_REQ - 1)) ? '0 : own + 1'b1;
    assign rx_ack    = (BYTE_READ == PS2_ACK) && (BYTE_ERROR_CODE == RX_OK);
    assign rx_resend = (BYTE_READ == PS2_RESEND) && (BYTE_ERROR_CODE == RX_OK);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state        <= IDLE;
            GRANT        <= '0;
            DONE         <= '0;
            ACK_OK       <= 1'b0;
            SEND_BYTE    <= 1'b0;
            BYTE_TO_SEND <= PS2_RESET;
            READ_ENABLE  <= 1'b0;
            BUSY         <= 1'b0;
            ptr          <= '0;
            own          <= '0;
            retry        <= '0;
            tcnt         <= '0;
`ifdef MOUSE_ARB_LOCK_EN
            locked       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
`ifdef MOUSE_ARB_LOCK_EN
                    // Locked owner keeps its grant; its next byte is latched now.
                    if (locked) begin
                        locked       <= 1'b0;
                        BYTE_TO_SEND <= own_byte;
                        SEND_BYTE    <= 1'b1;
                        BUSY         <= 1'b1;
                        state        <= SEND;
                    end else
`endif
                    if (pick_valid) begin
                        GRANT        <= pick;
                        own          <= pick_idx;
                        BYTE_TO_SEND <= pick_byte;
                        SEND_BYTE    <= 1'b1;
                        BUSY         <= 1'b1;
                        state        <= SEND;
                    end
                end
                SEND: begin
                    SEND_BYTE <= 1'b0;
                    state     <= WAIT_SENT;
                end
                WAIT_SENT: begin
                    if (BYTE_SENT) begin
                        tcnt        <= '0;
                        READ_ENABLE <= 1'b1;
                        state       <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    tcnt <= tcnt + 1'b1;
                    if (BYTE_READY) begin
                        if (rx_resend && !rx_ack && retry < RW'(MAX_RETRY)) begin
                            retry       <= retry + 1'b1;
                            READ_ENABLE <= 1'b0;
                            SEND_BYTE   <= 1'b1;
                            state       <= SEND;
                        end else begin
                            READ_ENABLE <= 1'b0;
                            DONE        <= GRANT;
                            ACK_OK      <= rx_ack;
                            state       <= FINISH;
                        end
                    end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        READ_ENABLE <= 1'b0;
                        DONE        <= GRANT;
                        ACK_OK      <= 1'b0;
                        state       <= FINISH;
                    end
                end
                FINISH: begin
                    DONE   <= '0;
                    ACK_OK <= 1'b0;
                    retry  <= '0;
                    BUSY   <= 1'b0;
                    state  <= IDLE;
`ifdef MOUSE_ARB_LOCK_EN
                    if (LOCK[own] && REQ[own]) begin
                        locked <= 1'b1;
                    end else
`endif
                    begin
                        GRANT <= '0;
                        ptr   <= nxt_ptr;
                    end
                end
                default: begin
                    state        <= IDLE;
                    GRANT        <= '0;
                    DONE         <= '0;
                    ACK_OK       <= 1'b0;
                    SEND_BYTE    <= 1'b0;
                    BYTE_TO_SEND <= PS2_RESET;
                    READ_ENABLE  <= 1'b0;
                    BUSY         <= 1'b0;
                    ptr          <= '0;
                    own          <= '0;
                    retry        <= '0;
                    tcnt         <= '0;
`ifdef MOUSE_ARB_LOCK_EN
                    locked       <= 1'b0;
`endif
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mouse_tx_arbiter.sv
// Vector table plus scoreboard bench for mouse_tx_arbiter.
// Lock sequence is exercised only when MOUSE_ARB_LOCK_EN is defined.
module tb_mouse_tx_arbiter;
    import mouse_pkg::*;

    localparam int N  = 2;
    localparam int TO = 100;
    localparam int MR = 2;

    logic           CLK = 1'b0;
    logic           RESET;
    logic [N-1:0]   REQ;
    logic [8*N-1:0] REQ_BYTE;
`ifdef MOUSE_ARB_LOCK_EN
    logic [N-1:0]   LOCK;
`endif
    logic [N-1:0]   GRANT;
    logic [N-1:0]   DONE;
    logic           ACK_OK;
    logic           SEND_BYTE;
    logic [7:0]     BYTE_TO_SEND;
    logic           BYTE_SENT;
    logic           READ_ENABLE;
    logic [7:0]     BYTE_READ;
    logic [1:0]     BYTE_ERROR_CODE;
    logic           BYTE_READY;
    logic           BUSY;

    always #5 CLK = ~CLK;

    mouse_tx_arbiter #(
        .NUM_REQ        (N),
        .TIMEOUT_CYCLES (TO),
        .MAX_RETRY      (MR)
    ) dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .REQ             (REQ),
        .REQ_BYTE        (REQ_BYTE),
`ifdef MOUSE_ARB_LOCK_EN
        .LOCK            (LOCK),
`endif
        .GRANT           (GRANT),
        .DONE            (DONE),
        .ACK_OK          (ACK_OK),
        .SEND_BYTE       (SEND_BYTE),
        .BYTE_TO_SEND    (BYTE_TO_SEND),
        .BYTE_SENT       (BYTE_SENT),
        .READ_ENABLE     (READ_ENABLE),
        .BYTE_READ       (BYTE_READ),
        .BYTE_ERROR_CODE (BYTE_ERROR_CODE),
        .BYTE_READY      (BYTE_READY),
        .BUSY            (BUSY)
    );

    typedef struct {
        logic [N-1:0] req;
        logic [7:0]   b0;
        logic [7:0]   b1;
        int           nfe;
        logic [7:0]   fin;
        logic [1:0]   err;
        int           sdly;
        int           rdly;
        int           owner;
        logic         ack;
        int           lat;
    } vec_t;

    vec_t         tbl[10];
    logic [N+7:0] send_q[$];
    logic [N:0]   done_q[$];
    int           pass_cnt = 0;
    int           chk_cnt  = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    // Scoreboard: every SEND_BYTE and DONE pulse must match the queue head.
    always @(negedge CLK) begin
        if (RESET === 1'b1) begin
            if (SEND_BYTE === 1'b1) begin
                if (send_q.size() == 0) begin
                    chk_cnt++;
                    $display("FAIL extra_send: grant %b byte %h", GRANT, BYTE_TO_SEND);
                end else begin
                    chk("send", {GRANT, BYTE_TO_SEND}, send_q.pop_front());
                end
            end
            if (DONE !== '0) begin
                if (done_q.size() == 0) begin
                    chk_cnt++;
                    $display("FAIL extra_done: done %b ack %b", DONE, ACK_OK);
                end else begin
                    chk("done", {DONE, ACK_OK}, done_q.pop_front());
                end
            end
        end
    end

    task automatic wait_send();
        int n = 0;
        while (SEND_BYTE !== 1'b1 && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 2000) begin
            chk_cnt++;
            $display("FAIL wait_send: none after %0d cycles", n);
        end
    endtask

    task automatic wait_done(inout int lat);
        while (DONE === '0 && lat < 1000) begin
            @(negedge CLK);
            lat++;
        end
        if (lat >= 1000) begin
            chk_cnt++;
            $display("FAIL wait_done: none after %0d cycles", lat);
        end
    endtask

    task automatic pulse_sent(input int dly);
        repeat (dly) @(negedge CLK);
        BYTE_SENT = 1'b1;
        @(negedge CLK);
        BYTE_SENT = 1'b0;
    endtask

    task automatic pulse_ready(input logic [7:0] b, input logic [1:0] e,
                               input int dly);
        repeat (dly) @(negedge CLK);
        BYTE_READ       = b;
        BYTE_ERROR_CODE = e;
        BYTE_READY      = 1'b1;
        @(negedge CLK);
        BYTE_READY      = 1'b0;
        BYTE_ERROR_CODE = RX_OK;
    endtask

    task automatic run_txn(input vec_t v, output int lat);
        int           nsend;
        logic [N-1:0] g;
        logic [7:0]   b;
        nsend = (v.nfe > MR) ? MR + 1 : v.nfe + 1;
        g     = N'(1) << v.owner;
        b     = (v.owner == 0) ? v.b0 : v.b1;
        for (int s = 0; s < nsend; s++) send_q.push_back({g, b});
        done_q.push_back({g, v.ack});
        REQ_BYTE = {v.b1, v.b0};
        REQ      = v.req;
        lat      = 0;
        for (int s = 0; s < nsend; s++) begin
            wait_send();
            pulse_sent(v.sdly);
            if (s < v.nfe) begin
                pulse_ready(PS2_RESEND, RX_OK, 3);
            end else if (v.rdly >= 0) begin
                pulse_ready(v.fin, v.err, v.rdly);
                lat = v.rdly + 1;
            end
        end
        wait_done(lat);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        tbl[0] = '{req:2'b11, b0:8'hF4, b1:8'hF3, nfe:0, fin:8'hFA, err:2'b00,
                   sdly:50, rdly:4, owner:0, ack:1'b1, lat:0};
        tbl[1] = '{req:2'b11, b0:8'hF4, b1:8'hF3, nfe:0, fin:8'hFA, err:2'b00,
                   sdly:2, rdly:2, owner:1, ack:1'b1, lat:0};
        tbl[2] = '{req:2'b01, b0:8'hE8, b1:8'h00, nfe:2, fin:8'hFA, err:2'b00,
                   sdly:3, rdly:2, owner:0, ack:1'b1, lat:0};
        tbl[3] = '{req:2'b10, b0:8'h00, b1:8'hE6, nfe:3, fin:8'hFA, err:2'b00,
                   sdly:3, rdly:2, owner:1, ack:1'b0, lat:0};
        tbl[4] = '{req:2'b11, b0:8'hF2, b1:8'hEB, nfe:0, fin:8'hFA, err:2'b01,
                   sdly:2, rdly:5, owner:0, ack:1'b0, lat:0};
        tbl[5] = '{req:2'b01, b0:8'hF5, b1:8'h00, nfe:0, fin:8'h00, err:2'b00,
                   sdly:2, rdly:1, owner:0, ack:1'b0, lat:0};
        tbl[6] = '{req:2'b10, b0:8'h00, b1:8'hE9, nfe:0, fin:8'hFA, err:2'b00,
                   sdly:4, rdly:99, owner:1, ack:1'b1, lat:100};
        tbl[7] = '{req:2'b10, b0:8'h00, b1:8'hEA, nfe:0, fin:8'hFA, err:2'b00,
                   sdly:4, rdly:-1, owner:1, ack:1'b0, lat:100};
        tbl[8] = '{req:2'b11, b0:8'hF6, b1:8'hE7, nfe:1, fin:8'hFA, err:2'b10,
                   sdly:2, rdly:2, owner:0, ack:1'b0, lat:0};
        tbl[9] = '{req:2'b11, b0:8'hF6, b1:8'hF3, nfe:0, fin:8'hFA, err:2'b00,
                   sdly:2, rdly:2, owner:1, ack:1'b1, lat:0};

        RESET           = 1'b1;
        REQ             = '0;
        REQ_BYTE        = '0;
        BYTE_SENT       = 1'b0;
        BYTE_READ       = '0;
        BYTE_ERROR_CODE = RX_OK;
        BYTE_READY      = 1'b0;
`ifdef MOUSE_ARB_LOCK_EN
        LOCK            = '0;
`endif
        #1 RESET = 1'b0;
        repeat (3) @(negedge CLK);
        chk("reset_outs", {GRANT, DONE, ACK_OK, SEND_BYTE, READ_ENABLE, BUSY,
                           BYTE_TO_SEND}, 32'h00FF);
        RESET = 1'b1;
        @(negedge CLK);

        pulse_ready(PS2_ACK, RX_OK, 1);
        @(negedge CLK);
        chk("idle_ready_ignored", {BUSY, GRANT, READ_ENABLE}, 32'h0);

        for (int i = 0; i < 10; i++) begin
            run_txn(tbl[i], lat);
            if (tbl[i].lat > 0) chk($sformatf("latency_%0d", i), lat, tbl[i].lat);
        end
        REQ = '0;
        repeat (3) @(negedge CLK);
        chk("idle_after", {BUSY, GRANT, READ_ENABLE}, 32'h0);

        // Asynchronous reset while waiting for the acknowledge.
        REQ_BYTE = {8'h00, 8'hF4};
        send_q.push_back({2'b01, 8'hF4});
        REQ = 2'b01;
        wait_send();
        pulse_sent(2);
        repeat (3) @(negedge CLK);
        chk("wait_ack_state", {BUSY, READ_ENABLE, GRANT}, 32'hD);
        #2 RESET = 1'b0;
        #1 chk("async_reset", {GRANT, DONE, ACK_OK, SEND_BYTE, READ_ENABLE, BUSY,
                               BYTE_TO_SEND}, 32'h00FF);
        REQ = '0;
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);

`ifdef MOUSE_ARB_LOCK_EN
        LOCK     = 2'b10;
        REQ_BYTE = {8'hF3, 8'hAA};
        REQ      = 2'b10;
        send_q.push_back({2'b10, 8'hF3});
        done_q.push_back({2'b10, 1'b1});
        send_q.push_back({2'b10, 8'h28});
        done_q.push_back({2'b10, 1'b1});
        send_q.push_back({2'b01, 8'hAA});
        done_q.push_back({2'b01, 1'b1});
        wait_send();
        REQ = 2'b11;
        pulse_sent(2);
        pulse_ready(PS2_ACK, RX_OK, 2);
        lat = 0;
        wait_done(lat);
        REQ_BYTE = {8'h28, 8'hAA};
        wait_send();
        LOCK = 2'b00;
        pulse_sent(2);
        pulse_ready(PS2_ACK, RX_OK, 2);
        lat = 0;
        wait_done(lat);
        REQ = 2'b01;
        wait_send();
        pulse_sent(2);
        pulse_ready(PS2_ACK, RX_OK, 2);
        lat = 0;
        wait_done(lat);
        REQ = '0;
        repeat (3) @(negedge CLK);
`endif

        chk("send_q_drained", send_q.size(), 0);
        chk("done_q_drained", done_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
